axis_out_packer: RTL
====================

AXIS_OUT_PACKER -- requirements
Module: axis_out_packer

Interface
REQ-001 Parameter: FIFO_DEPTH, default 16, output FIFO depth in words; power of two, at least `PE_NUM.
REQ-002 Parameter: LVL_W, default $clog2(FIFO_DEPTH)+1, width of the occupancy output.
REQ-003 Port: clk, input, 1, single clock; all logic on its rising edge.
REQ-004 Port: rst, input, 1, asynchronous, active-high reset.
REQ-005 Port: s_in_v, input, 1, serial word valid from the upstream parallel-to-serial stage; no backpressure is possible.
REQ-006 Port: s_in, input, `DATA_WIDTH*2, serial word (real/imag pair) from the upstream stage.
REQ-007 Port: m_axis_tvalid, output, 1, AXI-Stream valid.
REQ-008 Port: m_axis_tready, input, 1, AXI-Stream ready.
REQ-009 Port: m_axis_tdata, output, `DATA_WIDTH*2, AXI-Stream data.
REQ-010 Port: m_axis_tlast, output, 1, marks the last word of each `PE_NUM-word frame.
REQ-011 Port: clear_ovf, input, 1, synchronous clear of the overflow flag.
REQ-012 Port: overflow, output, 1, sticky flag: at least one word dropped.
REQ-013 Port: level, output, LVL_W, current FIFO occupancy.
REQ-014 Port: frame_cnt, output, 16, count of completed output frames; wraps.

Function
REQ-015 Input word counter wcnt (0..`PE_NUM-1) increments on every cycle with s_in_v=1, whether the word is stored or dropped; wraps from `PE_NUM-1 to 0.
REQ-016 Each accepted word is stored with tag last = (wcnt == `PE_NUM-1).
REQ-017 Write accepted when s_in_v=1 and (level < FIFO_DEPTH, or a pop occurs the same cycle).
REQ-018 Write with FIFO full and no pop: word dropped, overflow set to 1 at the next edge, level unchanged.
REQ-019 Pop occurs when m_axis_tvalid=1 and m_axis_tready=1.
REQ-020 m_axis_tvalid = (level != 0).
REQ-021 m_axis_tdata and m_axis_tlast = head entry (first-word fall-through).
REQ-022 Latency: a word written at edge N appears on the outputs in the cycle after edge N when the FIFO was empty.
REQ-023 Output is stable while m_axis_tvalid=1 and m_axis_tready=0 (AXI-Stream rule).
REQ-024 Level update: write only +1; pop only -1; both 0; never exceeds FIFO_DEPTH and never underflows.
REQ-025 Write and pop in the same cycle on an empty FIFO: not possible, because tvalid=0; the word is stored and level becomes 1.
REQ-026 frame_cnt increments on each pop with m_axis_tlast=1.
REQ-027 clear_ovf=1 clears overflow at the next edge; a simultaneous new drop wins, so overflow stays 1.
REQ-028 Read and write pointers wrap modulo FIFO_DEPTH.

Reset
REQ-029 rst=1 asynchronously clears wcnt, pointers, level, overflow and frame_cnt; m_axis_tvalid=0 and m_axis_tlast=0 immediately.
REQ-030 Reset mid-frame discards all buffered words; the first s_in_v after release is word 0 of a new frame.
REQ-031 FIFO storage RAM is not reset; data contents are don't-care while level=0.

Structure
REQ-032 `PE_NUM and `DATA_WIDTH come from the shared parameters.vh; no new global macros.
REQ-033 Storage and pointers form one sub-module, out_fifo: a synchronous first-word-fall-through FIFO, `DATA_WIDTH*2+1 bits wide, with async reset on its control logic.
REQ-034 wcnt, the overflow flag and frame_cnt live in axis_out_packer.

Verification
All scenarios use `PE_NUM=4, `DATA_WIDTH=16, FIFO_DEPTH=8.
REQ-035 Reset release, tready=1, s_in_v for 4 cycles with 0x00010002..0x00040005: same 4 words on tdata, tlast only on 0x00040005, frame_cnt=1.
REQ-036 tready=0, 12 consecutive valid words: level=8, overflow=1, words 9-12 absent; then tready=1: 8 words out, tlast on words 4 and 8, frame_cnt=2.
REQ-037 FIFO full (level=8), tready=1 and s_in_v=1 in the same cycle: level stays 8, new word accepted, overflow stays 0.
REQ-038 overflow=1, clear_ovf=1 together with a full-FIFO drop: overflow remains 1; clear_ovf=1 next cycle with no drop: overflow=0.
REQ-039 2 words of a frame, then rst pulse between clock edges: tvalid=0 and level=0 immediately; next 4 words: tlast on the 4th.
REQ-040 Random tready (50%) over 1000 frames with no drops: output sequence equals input sequence, tlast every 4th word, frame_cnt=1000 mod 65536.

Source files
------------

// File: rtl/axis_out_packer_pkg.sv
// axis_out_packer_pkg: shared widths and the FIFO entry layout for the output packer.
`ifndef PE_NUM
`define PE_NUM 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
package axis_out_packer_pkg;
  localparam int PE_NUM = `PE_NUM;
  localparam int DATA_WIDTH = `DATA_WIDTH;
  localparam int WORD_W = DATA_WIDTH * 2;
  localparam int ENTRY_W = WORD_W + 1;
  localparam int WCNT_W = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;
  typedef struct packed {
    logic last;
    logic [WORD_W-1:0] data;
  } entry_t;
endpackage

// File: rtl/out_fifo.sv
// out_fifo: first-word-fall-through FIFO of tagged words; control state async reset, storage not reset.
module out_fifo
  import axis_out_packer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  entry_t           wr_data,
  input  logic             rd_en,
  output entry_t           rd_data,
  output logic [LVL_W-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  entry_t mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  always_ff @(posedge clk) if (wr_en) mem[wptr] <= wr_data;
  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      level <= '0;
    end else begin
      if (wr_en) wptr <= wptr + AW'(1);
      if (rd_en) rptr <= rptr + AW'(1);
      level <= (wr_en && !rd_en) ? level + LVL_W'(1) : (rd_en && !wr_en) ? level - LVL_W'(1) : level;
    end
  end
  assign rd_data = mem[rptr];
endmodule

// File: rtl/axis_out_packer.sv
// axis_out_packer: buffers the serial word stream into an AXI-Stream output with per-frame tlast,
// dropping words when full and flagging it in a sticky overflow bit.
module axis_out_packer
  import axis_out_packer_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_in_v,
  input  logic [WORD_W-1:0] s_in,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [WORD_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  input  logic              clear_ovf,
  output logic              overflow,
  output logic [LVL_W-1:0]  level,
  output logic [15:0]       frame_cnt
);
  logic [WCNT_W-1:0] wcnt;
  logic pop, full, wr, drop, wlast;
  entry_t head, wr_entry;
  assign m_axis_tvalid = level != '0;
  assign pop = m_axis_tvalid && m_axis_tready;
  assign full = level == LVL_W'(FIFO_DEPTH);
  // A pop frees the head slot in the same cycle, so a full FIFO can still take a word.
  assign wr = s_in_v && (!full || pop);
  assign drop = s_in_v && !wr;
  assign wlast = wcnt == WCNT_W'(PE_NUM - 1);
  assign wr_entry = '{last: wlast, data: s_in};
  assign m_axis_tdata = head.data;
  assign m_axis_tlast = m_axis_tvalid && head.last;
  out_fifo #(.DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(wr),
    .wr_data(wr_entry),
    .rd_en(pop),
    .rd_data(head),
    .level(level)
  );
  // Word position advances on dropped words too, keeping frames aligned to the source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= '0;
      overflow <= 1'b0;
      frame_cnt <= '0;
    end else begin
      wcnt <= s_in_v ? (wlast ? '0 : wcnt + WCNT_W'(1)) : wcnt;
      overflow <= drop || (overflow && !clear_ovf);
      frame_cnt <= frame_cnt + 16'(pop && m_axis_tlast);
    end
  end
endmodule
